iommu_ctrl_master: RTL



---
 rtl/iommu_ctrl_master.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/iommu_ctrl_master.sv
// Single-outstanding AXI4 master for the IOMMU control register slave.
// Converts a cmd/resp handshake into single-beat AXI reads/writes with a per-phase timeout.
module iommu_ctrl_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_resetn,
  // command / response
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  // AXI write address
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awlock,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  // AXI write data
  output logic [31:0]       m_axi_wdata,
  output logic [15:0]       m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  // AXI write response
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  // AXI read address
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  // AXI read data
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              expired;

  // Single-beat transfers only; rlast carries no information.
  logic unused_rlast;
  assign unused_rlast = m_axi_rlast;

  // Phase budget used up on this cycle.
  assign expired = (cnt_q == CntW'(TIMEOUT - 1));

  // Next-state: phase sequencing, command capture, response capture and timeout abort.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_write ? cmd_wdata : '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = cmd_write ? StAw : StAr;
        end
      end
      StAw: begin
        if (m_axi_awready) begin
          state_d = StW;
        end else if (expired) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
      end
      StW: begin
        if (m_axi_wready) begin
          state_d = StB;
        end else if (expired) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
      end
      StB: begin
        // A response on the last budget cycle still counts as normal completion.
        if (m_axi_bvalid) begin
          state_d = StResp;
          err_d   = |m_axi_bresp;
        end else if (expired) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
      end
      StAr: begin
        if (m_axi_arready) begin
          state_d = StR;
        end else if (expired) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
      end
      StR: begin
        if (m_axi_rvalid) begin
          state_d = StResp;
          rdata_d = m_axi_rdata;
          err_d   = |m_axi_rresp;
        end else if (expired) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Phase timer restarts whenever the phase changes and idles outside AXI phases.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if ((state_d != state_q) || (state_q == StIdle) || (state_q == StResp)) begin
      cnt_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge ctrl_clk or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    cmd_ready     = ctrl_resetn & (state_q == StIdle);
    resp_valid    = (state_q == StResp);
    resp_err      = resp_valid & err_q;
    resp_rdata    = resp_valid ? rdata_q : '0;
    m_axi_awaddr  = addr_q;
    m_axi_awlen   = 8'd0;
    m_axi_awsize  = 3'b010;
    m_axi_awburst = 2'b01;
    m_axi_awlock  = 1'b0;
    m_axi_awcache = 4'b0011;
    m_axi_awprot  = 3'b000;
    m_axi_awvalid = (state_q == StAw);
    m_axi_wdata   = wdata_q;
    m_axi_wstrb   = 16'h000F;
    m_axi_wlast   = 1'b1;
    m_axi_wvalid  = (state_q == StW);
    m_axi_bready  = (state_q == StB);
    m_axi_araddr  = addr_q;
    m_axi_arlen   = 8'd0;
    m_axi_arsize  = 3'b010;
    m_axi_arburst = 2'b01;
    m_axi_arlock  = 1'b0;
    m_axi_arcache = 4'b0011;
    m_axi_arprot  = 3'b000;
    m_axi_arvalid = (state_q == StAr);
    m_axi_rready  = (state_q == StR);
  end

endmodule
